// File: rtl/text_memory_loader.sv
// text_memory_loader: receives a little-endian byte stream (word count N, then N words)
// and writes each assembled 32-bit word into the text memory write port.
// busy holds the core in reset for the whole load session.
module text_memory_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int TEXT_WORDS = 16384
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_wdata,
  output logic                  mem_wren,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  localparam logic [31:0] MAX_WORDS = 32'(TEXT_WORDS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  logic [2:0]            state_q,        state_d;
  logic [1:0]            byte_cnt_q,     byte_cnt_d;
  logic [31:0]           len_q,          len_d;
  logic [31:0]           word_q,         word_d;
  logic [CNT_WIDTH-1:0]  words_loaded_q, words_loaded_d;
  logic [ADDR_WIDTH-1:0] mem_address_q,  mem_address_d;
  logic [31:0]           mem_wdata_q,    mem_wdata_d;
  logic                  error_q,        error_d;

  logic                  ready;
  logic                  transfer;
  logic                  last_byte;
  logic [31:0]           len_next;
  logic [31:0]           word_next;
  logic [CNT_WIDTH-1:0]  count_inc;
  logic [31:0]           count_inc_ext;

  // Handshake and shift-in helpers; bytes enter at the top so byte0 ends up in [7:0].
  always_comb begin
    ready         = (state_q == ST_LEN) || (state_q == ST_DATA);
    transfer      = in_valid && ready;
    last_byte     = (byte_cnt_q == 2'd3);
    len_next      = {in_data, len_q[31:8]};
    word_next     = {in_data, word_q[31:8]};
    count_inc     = words_loaded_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    count_inc_ext = 32'(count_inc);
  end

  // Next-state logic for the load session FSM and its datapath registers.
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    len_d          = len_q;
    word_d         = word_q;
    words_loaded_d = words_loaded_q;
    mem_address_d  = mem_address_q;
    mem_wdata_d    = mem_wdata_q;
    error_d        = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d        = 1'b0;
          words_loaded_d = '0;
          byte_cnt_d     = 2'd0;
          len_d          = 32'd0;
          state_d        = ST_LEN;
        end
      end

      ST_LEN: begin
        if (transfer) begin
          len_d      = len_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            if (len_next == 32'd0) begin
              state_d = ST_DONE;
            end else if (len_next > MAX_WORDS) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (transfer) begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            mem_address_d = words_loaded_q[ADDR_WIDTH-1:0];
            mem_wdata_d   = word_next;
            state_d       = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        words_loaded_d = count_inc;
        if (count_inc_ext == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any session in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      byte_cnt_q     <= 2'd0;
      len_q          <= 32'd0;
      word_q         <= 32'd0;
      words_loaded_q <= '0;
      mem_address_q  <= '0;
      mem_wdata_q    <= 32'd0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      len_q          <= len_d;
      word_q         <= word_d;
      words_loaded_q <= words_loaded_d;
      mem_address_q  <= mem_address_d;
      mem_wdata_q    <= mem_wdata_d;
      error_q        <= error_d;
    end
  end

  // Outputs are decoded from the registered state, so they are glitch-free for one full cycle.
  always_comb begin
    in_ready     = ready;
    mem_wren     = (state_q == ST_WRITE);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    error        = error_q;
    mem_address  = mem_address_q;
    mem_wdata    = mem_wdata_q;
    words_loaded = words_loaded_q;
  end

endmodule

// File: tb/tb_text_memory_loader.sv
// tb_text_memory_loader: directed scenarios for the text memory loader.
module tb_text_memory_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic        busy;
  logic        done;
  logic        error;
  logic [14:0] words_loaded;

  int compared = 0;
  int mismatched = 0;

  logic [13:0] log_addr[$];
  logic [31:0] log_data[$];
  int          done_count = 0;
  int          ready_in_write = 0;

  text_memory_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Record every memory write and done pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_wren === 1'b1) begin
      log_addr.push_back(mem_address);
      log_data.push_back(mem_wdata);
      if (in_ready !== 1'b0) ready_in_write++;
    end
    if (done === 1'b1) done_count++;
  end

  // Hard stop if something wedges beyond all per-wait bounds.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] word_of(input int i);
    logic [15:0] v;
    v = i[15:0];
    return {v, ~v};
  endfunction

  // Offer one byte; returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (in_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      repeat (gap) @(negedge clock);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_idle_timeout: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    compared += 8;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    if (mem_wren !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_wren: got %b want 0", mem_wren); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error: got %b want 0", error); end
    if (words_loaded !== 15'd0) begin mismatched++; $display("[TB] FAIL reset_words_loaded: got %0d want 0", words_loaded); end
    if (mem_address !== 14'd0) begin mismatched++; $display("[TB] FAIL reset_mem_address: got %h want 0", mem_address); end
    if (mem_wdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_word();
    int base = log_addr.size();
    int dbase = done_count;
    pulse_start();
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0013, 0);
    compared++;
    if (mem_wren !== 1'b1) begin mismatched++; $display("[TB] FAIL single_wren_latency: got %b want 1", mem_wren); end
    wait_idle("single");
    compared += 5;
    if (log_addr.size() - base != 1) begin
      mismatched++; $display("[TB] FAIL single_write_count: got %0d want 1", log_addr.size() - base);
    end else begin
      if (log_addr[base] !== 14'd0) begin mismatched++; $display("[TB] FAIL single_addr: got %h want 0", log_addr[base]); end
      if (log_data[base] !== 32'h0000_0013) begin mismatched++; $display("[TB] FAIL single_data: got %h want 00000013", log_data[base]); end
    end
    if (done_count - dbase != 1) begin mismatched++; $display("[TB] FAIL single_done_pulses: got %0d want 1", done_count - dbase); end
    if (words_loaded !== 15'd1) begin mismatched++; $display("[TB] FAIL single_words_loaded: got %0d want 1", words_loaded); end
    compared++;
    if (mem_wdata !== 32'h0000_0013) begin mismatched++; $display("[TB] FAIL single_wdata_hold: got %h want 00000013", mem_wdata); end
  endtask

  task automatic test_gapped_three();
    logic [31:0] words[3];
    int base = log_addr.size();
    int dbase = done_count;
    int rbase = ready_in_write;
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h1234_5678;
    words[2] = 32'hA5A5_5A5A;
    pulse_start();
    send_word(32'd3, 1);
    for (int i = 0; i < 3; i++) send_word(words[i], 1);
    wait_idle("gapped");
    compared++;
    if (log_addr.size() - base != 3) begin
      mismatched++; $display("[TB] FAIL gapped_write_count: got %0d want 3", log_addr.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared += 2;
        if (log_addr[base+i] !== 14'(i)) begin mismatched++; $display("[TB] FAIL gapped_addr%0d: got %h want %h", i, log_addr[base+i], 14'(i)); end
        if (log_data[base+i] !== words[i]) begin mismatched++; $display("[TB] FAIL gapped_data%0d: got %h want %h", i, log_data[base+i], words[i]); end
      end
    end
    compared += 4;
    if (ready_in_write != rbase) begin mismatched++; $display("[TB] FAIL gapped_ready_in_write: got %0d cycles want 0", ready_in_write - rbase); end
    if (done_count - dbase != 1) begin mismatched++; $display("[TB] FAIL gapped_done_pulses: got %0d want 1", done_count - dbase); end
    if (words_loaded !== 15'd3) begin mismatched++; $display("[TB] FAIL gapped_words_loaded: got %0d want 3", words_loaded); end
    if (mem_address !== 14'd2) begin mismatched++; $display("[TB] FAIL gapped_addr_hold: got %h want 2", mem_address); end
  endtask

  task automatic test_zero_length();
    int base = log_addr.size();
    pulse_start();
    send_word(32'd0, 0);
    compared += 2;
    if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_done_timing: got %b want 1", done); end
    if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_error: got %b want 0", error); end
    @(negedge clock);
    compared += 4;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_done_width: got %b want 0", done); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_busy: got %b want 0", busy); end
    if (log_addr.size() != base) begin mismatched++; $display("[TB] FAIL zero_writes: got %0d want 0", log_addr.size() - base); end
    if (words_loaded !== 15'd0) begin mismatched++; $display("[TB] FAIL zero_words_loaded: got %0d want 0", words_loaded); end
  endtask

  task automatic test_overflow();
    int base = log_addr.size();
    int dbase = done_count;
    pulse_start();
    send_word(32'h0000_4001, 0);
    @(negedge clock);
    compared += 4;
    if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_error: got %b want 1", error); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_busy: got %b want 0", busy); end
    if (log_addr.size() != base) begin mismatched++; $display("[TB] FAIL ovf_writes: got %0d want 0", log_addr.size() - base); end
    if (done_count != dbase) begin mismatched++; $display("[TB] FAIL ovf_done: got %0d pulses want 0", done_count - dbase); end
    repeat (3) @(negedge clock);
    compared++;
    if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_error_sticky: got %b want 1", error); end
    pulse_start();
    compared += 2;
    if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_error_clear: got %b want 0", error); end
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_restart_busy: got %b want 1", busy); end
    send_word(32'd0, 0);
    wait_idle("ovf");
  endtask

  task automatic test_reset_mid_session();
    int base = log_addr.size();
    pulse_start();
    send_word(32'd3, 0);
    send_word(32'h0BAD_F00D, 0);
    send_word(32'hCAFE_0001, 0);
    @(negedge clock);
    compared += 2;
    if (words_loaded !== 15'd2) begin mismatched++; $display("[TB] FAIL rst_mid_words_before: got %0d want 2", words_loaded); end
    if (log_addr.size() - base != 2) begin mismatched++; $display("[TB] FAIL rst_mid_writes_before: got %0d want 2", log_addr.size() - base); end
    send_byte(8'h11);
    in_valid = 1'b1;
    in_data  = 8'h22;
    reset    = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    compared += 3;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    if (words_loaded !== 15'd0) begin mismatched++; $display("[TB] FAIL rst_mid_words_after: got %0d want 0", words_loaded); end
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h30 + i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    compared += 2;
    if (log_addr.size() - base != 2) begin mismatched++; $display("[TB] FAIL rst_mid_writes_after: got %0d want 2", log_addr.size() - base); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_stays_idle: got %b want 0", busy); end
  endtask

  task automatic test_full_image();
    int base = log_addr.size();
    int dbase = done_count;
    int bad = 0;
    int n;
    pulse_start();
    send_word(32'd16384, 0);
    for (int i = 0; i < 16384; i++) begin
      if (i == 5) start = 1'b1;
      send_word(word_of(i), 0);
      start = 1'b0;
    end
    wait_idle("full");
    n = log_addr.size() - base;
    compared += 3;
    if (n != 16384) begin mismatched++; $display("[TB] FAIL full_write_count: got %0d want 16384", n); end
    if (words_loaded !== 15'd16384) begin mismatched++; $display("[TB] FAIL full_words_loaded: got %0d want 16384", words_loaded); end
    if (done_count - dbase != 1) begin mismatched++; $display("[TB] FAIL full_done_pulses: got %0d want 1", done_count - dbase); end
    if (n == 16384) begin
      for (int i = 0; i < 16384; i++) begin
        if (log_addr[base+i] !== 14'(i) || log_data[base+i] !== word_of(i)) bad++;
      end
      compared += 3;
      if (bad != 0) begin mismatched++; $display("[TB] FAIL full_contents: got %0d bad writes want 0", bad); end
      if (log_addr[base+16383] !== 14'd16383) begin mismatched++; $display("[TB] FAIL full_last_addr: got %0d want 16383", log_addr[base+16383]); end
      if (log_data[base+16383] !== word_of(16383)) begin mismatched++; $display("[TB] FAIL full_last_data: got %h want %h", log_data[base+16383], word_of(16383)); end
    end
    compared++;
    if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL full_error: got %b want 0", error); end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting text_memory_loader bench");
    test_reset();
    test_single_word();
    test_gapped_three();
    test_zero_length();
    test_overflow();
    test_reset_mid_session();
    test_full_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
